// File: rtl/ex_pkg.sv
// ---------------------------------------------------------------------------
// ex_pkg -- shared definitions for the iterative multiply/divide unit.
//   * XLEN_DEF     : default operand/result width
//   * F_*          : funct encodings (bit 2 selects the divide family)
//   * state_e      : FSM state encoding of ex_muldiv
//   * rs1_signed / rs2_signed : operand signedness per funct
// ---------------------------------------------------------------------------
package ex_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // MUL only needs the low half, so it is run as unsigned*unsigned.
  function automatic logic rs1_signed(input logic [2:0] f);
    logic s;
    case (f)
      F_MULH, F_MULHSU, F_DIV, F_REM: s = 1'b1;
      default:                        s = 1'b0;
    endcase
    return s;
  endfunction

  function automatic logic rs2_signed(input logic [2:0] f);
    logic s;
    case (f)
      F_MULH, F_DIV, F_REM: s = 1'b1;
      default:              s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ex_div_iter.sv
// ---------------------------------------------------------------------------
// ex_div_iter -- unsigned restoring divider, one quotient bit per cycle.
//   clk, rst_n          : clock / async active-low reset
//   start               : load dividend/divisor (has priority over abort)
//   abort               : drop any in-flight division
//   dividend, divisor   : XLEN-bit unsigned magnitudes
//   done                : quotient/remainder valid (XLEN cycles after start)
//   quotient, remainder : XLEN-bit results
// ---------------------------------------------------------------------------
module ex_div_iter
  import ex_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CNT_W = $clog2(XLEN + 1);

  logic             busy_r;
  logic [CNT_W-1:0] cnt_r;
  logic [XLEN-1:0]  quo_r;
  logic [XLEN-1:0]  rem_r;
  logic [XLEN-1:0]  dvs_r;
  logic [XLEN:0]    partial_s;
  logic [XLEN:0]    diff_s;

  // Trial subtraction: shift the next dividend bit into the partial remainder.
  always_comb begin
    partial_s = {rem_r, quo_r[XLEN-1]};
    diff_s    = partial_s - {1'b0, dvs_r};
  end

  // Iteration registers; quo_r doubles as the dividend shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      cnt_r  <= '0;
      quo_r  <= '0;
      rem_r  <= '0;
      dvs_r  <= '0;
    end else if (start) begin
      busy_r <= 1'b1;
      cnt_r  <= '0;
      quo_r  <= dividend;
      rem_r  <= '0;
      dvs_r  <= divisor;
    end else if (abort) begin
      busy_r <= 1'b0;
      cnt_r  <= '0;
    end else if (busy_r && (cnt_r != CNT_W'(XLEN))) begin
      cnt_r <= cnt_r + CNT_W'(1);
      if (!diff_s[XLEN]) begin
        rem_r <= diff_s[XLEN-1:0];
        quo_r <= {quo_r[XLEN-2:0], 1'b1};
      end else begin
        rem_r <= partial_s[XLEN-1:0];
        quo_r <= {quo_r[XLEN-2:0], 1'b0};
      end
    end else begin
      busy_r <= busy_r;
    end
  end

  assign done      = busy_r && (cnt_r == CNT_W'(XLEN));
  assign quotient  = quo_r;
  assign remainder = rem_r;

endmodule

// File: rtl/ex_muldiv.sv
// ---------------------------------------------------------------------------
// ex_muldiv -- iterative RV-M style multiply/divide execution unit.
//   clk, rst_n            : clock / async active-low reset
//   in_valid/in_ready     : operation handshake (funct_i, reg1_i, reg2_i,
//                           wd_i, wreg_i)
//   flush_i               : kill in-flight op, return to IDLE
//   out_valid/out_ready   : result handshake (wd_o, wreg_o, wdata_o,
//                           illegal_o held while out_valid && !out_ready)
//   busy_o                : high whenever the FSM is not IDLE
// Build option: define EX_MULDIV_DIV_EN to include the divider. Without it,
// divide-family ops complete after one cycle with illegal_o=1 and wdata_o=0.
// Both multiplier and divider work on magnitudes; signs are applied when the
// result is captured.
// ---------------------------------------------------------------------------
module ex_muldiv
  import ex_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int MUL_BPC = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct_i,
  input  logic [XLEN-1:0] reg1_i,
  input  logic [XLEN-1:0] reg2_i,
  input  logic [4:0]      wd_i,
  input  logic            wreg_i,
  input  logic            flush_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      wd_o,
  output logic            wreg_o,
  output logic [XLEN-1:0] wdata_o,
  output logic            illegal_o,
  output logic            busy_o
);

  localparam int MUL_STEPS = XLEN / MUL_BPC;
  localparam int CNT_W     = $clog2(XLEN + 1);

  state_e            state_r;
  state_e            state_nxt_s;
  logic              accept_s;
  logic              neg_a_s;
  logic              neg_b_s;
  logic [XLEN-1:0]   mag_a_s;
  logic [XLEN-1:0]   mag_b_s;

  logic [2:0]        funct_r;
  logic [4:0]        wd_r;
  logic              wreg_r;
  logic              neg_a_r;
  logic              neg_b_r;
  logic [2*XLEN-1:0] acc_r;
  logic [2*XLEN-1:0] mcand_r;
  logic [XLEN-1:0]   mplier_r;
  logic [CNT_W-1:0]  cnt_r;

  logic [2*XLEN-1:0] pp_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   mul_res_s;

  logic              load_s;
  logic [XLEN-1:0]   res_data_s;
  logic              res_wreg_s;
  logic              res_ill_s;

  logic              out_valid_r;
  logic [4:0]        wd_out_r;
  logic              wreg_out_r;
  logic [XLEN-1:0]   wdata_r;
  logic              illegal_r;

  assign in_ready = (state_r == ST_IDLE) && !flush_i;
  assign accept_s = in_valid && in_ready;
  assign busy_o   = (state_r != ST_IDLE);

  // Operand magnitudes and signs for the offered operation.
  always_comb begin
    neg_a_s = rs1_signed(funct_i) && reg1_i[XLEN-1];
    neg_b_s = rs2_signed(funct_i) && reg2_i[XLEN-1];
    mag_a_s = neg_a_s ? (-reg1_i) : reg1_i;
    mag_b_s = neg_b_s ? (-reg2_i) : reg2_i;
  end

`ifdef EX_MULDIV_DIV_EN
  logic            div_done_s;
  logic [XLEN-1:0] div_quo_s;
  logic [XLEN-1:0] div_rem_s;
  logic [XLEN-1:0] quo_fix_s;
  logic [XLEN-1:0] rem_fix_s;
  logic [XLEN-1:0] rs1_r;
  logic            div_zero_r;
  logic            div_ovf_r;

  ex_div_iter #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (accept_s && funct_i[2]),
    .abort     (state_r != ST_DIV),
    .dividend  (mag_a_s),
    .divisor   (mag_b_s),
    .done      (div_done_s),
    .quotient  (div_quo_s),
    .remainder (div_rem_s)
  );

  // Quotient takes the xor of operand signs, remainder the dividend sign.
  always_comb begin
    quo_fix_s = (neg_a_r ^ neg_b_r) ? (-div_quo_s) : div_quo_s;
    rem_fix_s = neg_a_r ? (-div_rem_s) : div_rem_s;
  end

  // Special divide cases are detected at accept and bypass the iteration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_r      <= '0;
      div_zero_r <= 1'b0;
      div_ovf_r  <= 1'b0;
    end else if (accept_s) begin
      rs1_r      <= reg1_i;
      div_zero_r <= (reg2_i == {XLEN{1'b0}});
      div_ovf_r  <= ((funct_i == F_DIV) || (funct_i == F_REM)) &&
                    (reg1_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                    (reg2_i == {XLEN{1'b1}});
    end else begin
      rs1_r <= rs1_r;
    end
  end
`endif

  // Partial product for the MUL_BPC multiplier bits retired this cycle.
  always_comb begin
    pp_s = '0;
    for (int i = 0; i < MUL_BPC; i++) begin
      if (mplier_r[i]) begin
        pp_s = pp_s + (mcand_r << i);
      end else begin
        pp_s = pp_s;
      end
    end
    prod_s    = (neg_a_r ^ neg_b_r) ? (-acc_r) : acc_r;
    mul_res_s = (funct_r == F_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
  end

  // Next state and the result captured on entry to DONE.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    res_data_s  = '0;
    res_wreg_s  = wreg_r;
    res_ill_s   = 1'b0;
    if (flush_i) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_nxt_s = funct_i[2] ? ST_DIV : ST_MUL;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_MUL: begin
          if (cnt_r == CNT_W'(MUL_STEPS)) begin
            state_nxt_s = ST_DONE;
            load_s      = 1'b1;
            res_data_s  = mul_res_s;
          end else begin
            state_nxt_s = ST_MUL;
          end
        end
        ST_DIV: begin
`ifdef EX_MULDIV_DIV_EN
          // funct_r[1] selects REM/REMU over DIV/DIVU.
          if (div_zero_r) begin
            state_nxt_s = ST_DONE;
            load_s      = 1'b1;
            res_data_s  = funct_r[1] ? rs1_r : {XLEN{1'b1}};
          end else if (div_ovf_r) begin
            state_nxt_s = ST_DONE;
            load_s      = 1'b1;
            res_data_s  = funct_r[1] ? {XLEN{1'b0}} : rs1_r;
          end else if (div_done_s) begin
            state_nxt_s = ST_DONE;
            load_s      = 1'b1;
            res_data_s  = funct_r[1] ? rem_fix_s : quo_fix_s;
          end else begin
            state_nxt_s = ST_DIV;
          end
`else
          state_nxt_s = ST_DONE;
          load_s      = 1'b1;
          res_wreg_s  = 1'b0;
          res_ill_s   = 1'b1;
`endif
        end
        ST_DONE: begin
          if (out_valid_r && out_ready) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand capture and shift-add multiplier iteration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      funct_r  <= 3'b000;
      wd_r     <= 5'd0;
      wreg_r   <= 1'b0;
      neg_a_r  <= 1'b0;
      neg_b_r  <= 1'b0;
      acc_r    <= '0;
      mcand_r  <= '0;
      mplier_r <= '0;
      cnt_r    <= '0;
    end else if (accept_s) begin
      funct_r  <= funct_i;
      wd_r     <= wd_i;
      wreg_r   <= wreg_i && (wd_i != 5'd0);
      neg_a_r  <= neg_a_s;
      neg_b_r  <= neg_b_s;
      acc_r    <= '0;
      mcand_r  <= {{XLEN{1'b0}}, mag_a_s};
      mplier_r <= mag_b_s;
      cnt_r    <= '0;
    end else if ((state_r == ST_MUL) && (cnt_r != CNT_W'(MUL_STEPS))) begin
      acc_r    <= acc_r + pp_s;
      mcand_r  <= mcand_r << MUL_BPC;
      mplier_r <= mplier_r >> MUL_BPC;
      cnt_r    <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Output registers: loaded entering DONE, held in DONE, zero elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      wd_out_r    <= 5'd0;
      wreg_out_r  <= 1'b0;
      wdata_r     <= '0;
      illegal_r   <= 1'b0;
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      wd_out_r    <= wd_r;
      wreg_out_r  <= res_wreg_s;
      wdata_r     <= res_data_s;
      illegal_r   <= res_ill_s;
    end else if (state_nxt_s != ST_DONE) begin
      out_valid_r <= 1'b0;
      wd_out_r    <= 5'd0;
      wreg_out_r  <= 1'b0;
      wdata_r     <= '0;
      illegal_r   <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign out_valid = out_valid_r;
  assign wd_o      = wd_out_r;
  assign wreg_o    = wreg_out_r;
  assign wdata_o   = wdata_r;
  assign illegal_o = illegal_r;

endmodule

// File: tb/tb_ex_muldiv.sv
// ---------------------------------------------------------------------------
// tb_ex_muldiv -- directed self-checking bench for ex_muldiv (XLEN=32,
// MUL_BPC=1). Divide expectations follow EX_MULDIV_DIV_EN.
// ---------------------------------------------------------------------------
module tb_ex_muldiv;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  funct_i = 3'b000;
  logic [31:0] reg1_i = 32'd0;
  logic [31:0] reg2_i = 32'd0;
  logic [4:0]  wd_i = 5'd0;
  logic        wreg_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        illegal_o;
  logic        busy_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_muldiv #(.XLEN(32), .MUL_BPC(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .funct_i   (funct_i),
    .reg1_i    (reg1_i),
    .reg2_i    (reg2_i),
    .wd_i      (wd_i),
    .wreg_i    (wreg_i),
    .flush_i   (flush_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .wd_o      (wd_o),
    .wreg_o    (wreg_o),
    .wdata_o   (wdata_o),
    .illegal_o (illegal_o),
    .busy_o    (busy_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer one op, then wait (bounded) for out_valid; returns latency.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wd, input logic wr, output int lat);
    @(negedge clk);
    funct_i  = f;
    reg1_i   = a;
    reg2_i   = b;
    wd_i     = wd;
    wreg_i   = wr;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] wd, input logic wr,
                        input logic [31:0] exp_data, input int exp_lat,
                        input logic exp_wreg, input logic exp_ill);
    int lat;
    @(negedge clk);
    check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    issue(f, a, b, wd, wr, lat);
    check_eq({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, "_wdata"}, 64'(wdata_o), 64'(exp_data));
    check_eq({tag, "_wd"}, 64'(wd_o), 64'(wd));
    check_eq({tag, "_wreg"}, 64'(wreg_o), 64'(exp_wreg));
    check_eq({tag, "_illegal"}, 64'(illegal_o), 64'(exp_ill));
    @(posedge clk); #1;
    check_eq({tag, "_idle_after"}, 64'({out_valid, busy_o, wdata_o}), 64'd0);
  endtask

  initial begin
    int lat;
    int seen;

    // Reset state
    #12;
    check_eq("reset_out_valid", 64'(out_valid), 64'd0);
    check_eq("reset_busy", 64'(busy_o), 64'd0);
    check_eq("reset_outs", 64'({wd_o, wreg_o, wdata_o, illegal_o}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("reset_in_ready", 64'(in_ready), 64'd1);

    // Multiply family
    run_op("mul_7x-3",     OP_MUL,    32'd7,          32'hFFFF_FFFD, 5'd3, 1'b1, 32'hFFFF_FFEB, 33, 1'b1, 1'b0);
    run_op("mulhu_max",    OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd4, 1'b1, 32'hFFFF_FFFE, 33, 1'b1, 1'b0);
    run_op("mulhsu_max",   OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd5, 1'b1, 32'hFFFF_FFFF, 33, 1'b1, 1'b0);
    run_op("mulh_min",     OP_MULH,   32'h8000_0000,  32'h8000_0000, 5'd6, 1'b1, 32'h4000_0000, 33, 1'b1, 1'b0);
    run_op("mulh_neg",     OP_MULH,   32'hFFFF_FFF9,  32'd3,         5'd7, 1'b1, 32'hFFFF_FFFF, 33, 1'b1, 1'b0);
    run_op("mul_shift",    OP_MUL,    32'h1234_5678,  32'h10,        5'd8, 1'b1, 32'h2345_6780, 33, 1'b1, 1'b0);
    run_op("mul_wd0",      OP_MUL,    32'd3,          32'd4,         5'd0, 1'b1, 32'd12,        33, 1'b0, 1'b0);
    run_op("mul_wreg0",    OP_MUL,    32'd3,          32'd4,         5'd9, 1'b0, 32'd12,        33, 1'b0, 1'b0);

`ifdef EX_MULDIV_DIV_EN
    run_op("div_-7/2",     OP_DIV,    32'hFFFF_FFF9,  32'd2,         5'd10, 1'b1, 32'hFFFF_FFFD, 33, 1'b1, 1'b0);
    run_op("rem_-7/2",     OP_REM,    32'hFFFF_FFF9,  32'd2,         5'd11, 1'b1, 32'hFFFF_FFFF, 33, 1'b1, 1'b0);
    run_op("div_7/-2",     OP_DIV,    32'd7,          32'hFFFF_FFFE, 5'd12, 1'b1, 32'hFFFF_FFFD, 33, 1'b1, 1'b0);
    run_op("rem_7/-2",     OP_REM,    32'd7,          32'hFFFF_FFFE, 5'd13, 1'b1, 32'd1,         33, 1'b1, 1'b0);
    run_op("divu_100/7",   OP_DIVU,   32'd100,        32'd7,         5'd14, 1'b1, 32'd14,        33, 1'b1, 1'b0);
    run_op("remu_100/7",   OP_REMU,   32'd100,        32'd7,         5'd15, 1'b1, 32'd2,         33, 1'b1, 1'b0);
    run_op("divu_by0",     OP_DIVU,   32'd5,          32'd0,         5'd16, 1'b1, 32'hFFFF_FFFF, 1,  1'b1, 1'b0);
    run_op("remu_by0",     OP_REMU,   32'd5,          32'd0,         5'd17, 1'b1, 32'd5,         1,  1'b1, 1'b0);
    run_op("div_by0",      OP_DIV,    32'hFFFF_FFF9,  32'd0,         5'd18, 1'b1, 32'hFFFF_FFFF, 1,  1'b1, 1'b0);
    run_op("div_ovf",      OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd19, 1'b1, 32'h8000_0000, 1,  1'b1, 1'b0);
    run_op("rem_ovf",      OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd20, 1'b1, 32'd0,         1,  1'b1, 1'b0);
`else
    run_op("divu_nodiv",   OP_DIVU,   32'd9,          32'd3,         5'd10, 1'b1, 32'd0,         1,  1'b0, 1'b1);
    run_op("rem_nodiv",    OP_REM,    32'hFFFF_FFF9,  32'd2,         5'd11, 1'b1, 32'd0,         1,  1'b0, 1'b1);
    run_op("div_nodiv",    OP_DIV,    32'd8,          32'd0,         5'd12, 1'b1, 32'd0,         1,  1'b0, 1'b1);
`endif

    // Back-pressure: result must hold while out_ready is low
    out_ready = 1'b0;
    issue(OP_MUL, 32'd2, 32'd3, 5'd7, 1'b1, lat);
    check_eq("stall_latency", 64'(lat), 64'd33);
    for (int i = 0; i < 5; i++) begin
      check_eq("stall_hold", 64'({out_valid, in_ready, wd_o, wreg_o, wdata_o}),
               64'({1'b1, 1'b0, 5'd7, 1'b1, 32'd6}));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("stall_release", 64'({out_valid, busy_o, in_ready}), 64'({1'b0, 1'b0, 1'b1}));

    // Flush mid-operation: no result, IDLE next edge
    @(negedge clk);
`ifdef EX_MULDIV_DIV_EN
    funct_i = OP_DIV;
`else
    funct_i = OP_MUL;
`endif
    reg1_i = 32'd100; reg2_i = 32'd7; wd_i = 5'd3; wreg_i = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    check_eq("flush_busy_before", 64'(busy_o), 64'd1);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    check_eq("flush_idle", 64'({busy_o, out_valid}), 64'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    check_eq("flush_no_result", 64'(seen), 64'd0);

    // Flush wins over in_valid
    @(negedge clk);
    funct_i = OP_MUL; reg1_i = 32'd2; reg2_i = 32'd2; in_valid = 1'b1; flush_i = 1'b1;
    #1;
    check_eq("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; flush_i = 1'b0;
    check_eq("flush_no_accept", 64'(busy_o), 64'd0);

    // Reset mid-MUL aborts, then first accept works straight away
    @(negedge clk);
    funct_i = OP_MUL; reg1_i = 32'd5; reg2_i = 32'd5; wd_i = 5'd2; wreg_i = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_outs", 64'({out_valid, busy_o, wd_o, wreg_o, wdata_o, illegal_o}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("mul_after_rst", OP_MUL, 32'd5, 32'd5, 5'd2, 1'b1, 32'd25, 33, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 Parameter: XLEN, 32, operand/result width (even, >=8).
REQ-002 Parameter: MUL_BPC, 1, multiplier bits retired per cycle (must divide XLEN).
REQ-003 Ports: clk  in  1  sole clock, rising edge; all state on this edge.
REQ-004 Ports: rst_n  in  1  asynchronous active-low reset.
REQ-005 Ports: in_valid  in  1  operation offered; in_ready  out  1  unit can accept.
REQ-006 Ports: funct_i  in  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 Ports: reg1_i, reg2_i  in  XLEN  rs1/rs2 operands; wd_i  in  5  dest reg; wreg_i  in  1  write-enable.
REQ-008 Ports: flush_i  in  1  kill in-flight op.
REQ-009 Ports: out_valid  out  1; out_ready  in  1; wd_o  out  5; wreg_o  out  1; wdata_o  out  XLEN; illegal_o  out  1.
REQ-010 Ports: busy_o  out  1  high in any state except IDLE (drives pipeline stall).

Function
REQ-011 FSM states IDLE, MUL, DIV, DONE; in_ready SHALL equal (state==IDLE) && !flush_i.
REQ-012 Accept on in_valid && in_ready: latch funct, operands (sign-adjusted per op), wd_i, wreg_i; go MUL (funct[2]=0) or DIV (funct[2]=1).
REQ-013 MUL: shift-add over XLEN/MUL_BPC cycles, 2*XLEN-bit product; then DONE.
REQ-014 DIV: restoring, one quotient bit per cycle, XLEN cycles on magnitudes; result signs fixed in last cycle; then DONE.
REQ-015 Result select: MUL low XLEN bits; MULH/MULHSU/MULHU high XLEN bits of signed*signed/signed*unsigned/unsigned*unsigned; DIV/DIVU quotient; REM/REMU remainder (sign of dividend).
REQ-016 Divide by zero: DIV/DIVU -> all ones, REM/REMU -> reg1_i; DONE on next edge after accept (latency 1).
REQ-017 Signed overflow (reg1_i = -2^(XLEN-1), reg2_i = -1): DIV -> reg1_i, REM -> 0; latency 1.
REQ-018 DONE: out_valid=1; wd_o, wreg_o, wdata_o, illegal_o stable until out_valid && out_ready; then IDLE next edge; no back-to-back accept in the same cycle.
REQ-019 Outside DONE: out_valid=0, wd_o=0, wreg_o=0, wdata_o=0, illegal_o=0.
REQ-020 wd_i==0: op executes normally; wreg_o forced 0.
REQ-021 flush_i in any state: next edge -> IDLE, no result produced; flush_i with in_valid: flush wins, nothing accepted.
REQ-022 Nominal latency accept->out_valid: MUL XLEN/MUL_BPC+1 cycles, DIV XLEN+1 cycles.

Reset
REQ-023 rst_n low: state IDLE, all datapath registers 0, all outputs 0 except in_ready (1 once rst_n high).
REQ-024 Reset mid-operation aborts without producing a result; first accept legal on first edge with rst_n high.

Configuration
REQ-025 Macro EX_MULDIV_DIV_EN defined: divider and REQ-014/016/017 present, illegal_o constant 0.
REQ-026 Macro undefined: no divider logic; funct[2]=1 accepted, DONE next edge, wdata_o=0, wreg_o=0, illegal_o=1; MUL ops unchanged.

Structure
REQ-027 Package ex_pkg: funct encodings, FSM state enum, default XLEN.
REQ-028 Sub-module ex_div_iter: restoring divider (start, dividend, divisor -> done, quotient, remainder), instantiated only under EX_MULDIV_DIV_EN; multiplier stays in ex_muldiv.

Verification
REQ-029 MUL 7*-3 (XLEN=32, MUL_BPC=1) -> out_valid at cycle 33, wdata_o=0xFFFFFFEB.
REQ-030 MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
REQ-031 DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF, cycle 33; DIVU 5/0 -> 0xFFFFFFFF at cycle 1; DIV 0x80000000/-1 -> 0x80000000.
REQ-032 out_ready held low 5 cycles in DONE -> outputs stable, in_ready=0; release -> IDLE next edge.
REQ-033 flush_i at cycle 10 of DIV -> no out_valid, IDLE next edge; rst_n low mid-MUL -> all outputs 0.
REQ-034 Build without EX_MULDIV_DIV_EN: DIVU 9/3 -> cycle 1 out_valid, illegal_o=1, wdata_o=0, wreg_o=0.
